// File: rtl/data_cache_nway_if.sv
// CPU-side and memory-side handshake bundle for data_cache_nway.
// slave = cache view, master = requester / memory-model view.
interface data_cache_nway_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;
  logic          cpu_busy;
  logic          miss_data_cache;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, cpu_busy, miss_data_cache,
           mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, cpu_busy, miss_data_cache,
           mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_cache_nway.sv
// N-way set-associative write-through data cache with true-LRU and block fill.
// Optional DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module data_cache_nway #(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned SETS  = 64,
  parameter int unsigned WORDS = 8,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16
) (
  input  logic               clk,
  input  logic               rst,
  data_cache_nway_if.slave   bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
`endif
);
  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = AW - 1 - OFF_W - IDX_W;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, WRITE_MEM} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               we_q, we_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [OFF_W-1:0]   cnt_q, cnt_d;
  logic [WAY_W-1:0]   vic_q, vic_d;
  logic               wr_done_q, wr_done_d;

  logic               valid_q [WAYS][SETS];
  logic [WAY_W-1:0]   age_q   [WAYS][SETS];
  logic [TAG_W-1:0]   tag_q   [WAYS][SETS];
  logic [DW-1:0]      data_q  [WAYS][SETS][WORDS];

  logic [TAG_W-1:0]   tag_f;
  logic [IDX_W-1:0]   idx_f;
  logic [OFF_W-1:0]   off_f;
  assign tag_f = addr_q[AW-1 -: TAG_W];
  assign idx_f = addr_q[IDX_W+OFF_W -: IDX_W];
  assign off_f = addr_q[OFF_W:1];

  logic               hit, inv_found, rd_hit;
  logic [WAY_W-1:0]   hit_way, vic_sel, lru_way, data_way;
  logic [OFF_W-1:0]   data_off;
  logic [DW-1:0]      data_val;
  logic               lru_en, data_we, tag_we, val_clr, val_set;

  // Lowest-index invalid way wins; otherwise the oldest (age == WAYS-1).
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    vic_sel   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[w][idx_f] && tag_q[w][idx_f] == tag_f) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[w][idx_f]) begin
        inv_found = 1'b1;
        vic_sel   = WAY_W'(w);
      end
    end
    if (!inv_found) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_q[w][idx_f] == WAY_W'(WAYS - 1)) vic_sel = WAY_W'(w);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    vic_d     = vic_q;
    wr_done_d = 1'b0;
    lru_en    = 1'b0;
    lru_way   = hit_way;
    data_we   = 1'b0;
    data_way  = hit_way;
    data_off  = off_f;
    data_val  = wdata_q;
    tag_we    = 1'b0;
    val_clr   = 1'b0;
    val_set   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          state_d = LOOKUP;
          addr_d  = bus.cpu_addr;
          we_d    = bus.cpu_we;
          wdata_d = bus.cpu_wdata;
        end
      end
      LOOKUP: begin
        if (hit) begin
          lru_en  = 1'b1;
          data_we = we_q;
          state_d = we_q ? WRITE_MEM : IDLE;
        end else begin
          // Victim is invalidated and retagged on the way into FILL.
          vic_d   = vic_sel;
          tag_we  = 1'b1;
          val_clr = 1'b1;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (bus.mem_ack) begin
          data_we  = 1'b1;
          data_way = vic_q;
          data_off = cnt_q;
          data_val = bus.mem_rdata;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == OFF_W'(WORDS - 1)) begin
            val_set = 1'b1;
            lru_en  = 1'b1;
            lru_way = vic_q;
            state_d = LOOKUP;
          end
        end
      end
      WRITE_MEM: begin
        if (bus.mem_ack) begin
          wr_done_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      vic_q     <= '0;
      wr_done_q <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_q[w][s] <= 1'b0;
          age_q[w][s]   <= WAY_W'(w);
        end
      end
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      vic_q     <= vic_d;
      wr_done_q <= wr_done_d;
      if (val_clr) valid_q[vic_sel][idx_f] <= 1'b0;
      if (val_set) valid_q[vic_q][idx_f]   <= 1'b1;
      if (lru_en) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == lru_way)
            age_q[w][idx_f] <= '0;
          else if (age_q[w][idx_f] < age_q[lru_way][idx_f])
            age_q[w][idx_f] <= age_q[w][idx_f] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_q[data_way][idx_f][data_off] <= data_val;
    if (tag_we)  tag_q[vic_sel][idx_f]            <= tag_f;
  end

  assign rd_hit = (state_q == LOOKUP) && hit && !we_q;

  always_comb begin
    bus.cpu_busy        = (state_q != IDLE);
    bus.cpu_ready       = rd_hit || wr_done_q;
    bus.cpu_rdata       = rd_hit ? data_q[hit_way][idx_f][off_f] : '0;
    bus.miss_data_cache = (state_q == LOOKUP) && !hit;
    bus.mem_rd          = (state_q == FILL);
    bus.mem_wr          = (state_q == WRITE_MEM);
    bus.mem_addr        = '0;
    bus.mem_wdata       = '0;
    if (state_q == FILL) begin
      bus.mem_addr = {tag_f, idx_f, cnt_q, 1'b0};
    end else if (state_q == WRITE_MEM) begin
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        replay_q, replay_d;
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Only the first LOOKUP of a request counts; the post-fill replay is skipped.
  always_comb begin
    replay_d   = (state_q == FILL) ? 1'b1 : (state_q == IDLE) ? 1'b0 : replay_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == LOOKUP && !replay_q) begin
      if (hit && hit_cnt_q != '1)         hit_cnt_d  = hit_cnt_q + 1'b1;
      else if (!hit && miss_cnt_q != '1)  miss_cnt_d = miss_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      replay_q   <= replay_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_data_cache_nway.sv
// Directed self-checking bench for data_cache_nway at default parameters.
// Memory model returns mem_addr ^ 16'hA5A5 after ack_delay wait cycles.
module tb_data_cache_nway;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_cache_nway_if #(.AW(16), .DW(16)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  data_cache_nway #(.WAYS(2), .SETS(64), .WORDS(8), .AW(16), .DW(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int ack_delay = 0;
  int wait_cnt  = 0;
  assign bus.mem_rdata = bus.mem_addr ^ 16'hA5A5;
  assign bus.mem_ack   = (bus.mem_rd || bus.mem_wr) && (wait_cnt >= ack_delay);
  always @(posedge clk)
    wait_cnt <= ((bus.mem_rd || bus.mem_wr) && !bus.mem_ack) ? wait_cnt + 1 : 0;

  logic [15:0] rd_q[$];
  logic [15:0] wr_a[$];
  logic [15:0] wr_d[$];
  always @(negedge clk) begin
    if (bus.mem_rd && bus.mem_ack) rd_q.push_back(bus.mem_addr);
    if (bus.mem_wr) begin
      wr_a.push_back(bus.mem_addr);
      wr_d.push_back(bus.mem_wdata);
    end
  end

  int tests  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output int miss_cyc, output logic [15:0] rdata);
    lat = 0; miss_cyc = 0; rdata = '0;
    @(negedge clk);
    rd_q.delete(); wr_a.delete(); wr_d.delete();
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus.miss_data_cache && miss_cyc == 0) miss_cyc = n;
      if (bus.cpu_ready) begin
        lat = n;
        rdata = bus.cpu_rdata;
        break;
      end
    end
    @(negedge clk);
    check("ready_one_cycle", {31'd0, bus.cpu_ready}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  int lat, mc, bad;
  logic [15:0] rdata;

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ready",  {31'd0, bus.cpu_ready}, 32'd0);
    check("rst_busy",   {31'd0, bus.cpu_busy}, 32'd0);
    check("rst_miss",   {31'd0, bus.miss_data_cache}, 32'd0);
    check("rst_memrw",  {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
    check("rst_maddr",  {16'd0, bus.mem_addr}, 32'd0);
    rst = 1'b1;

    // cold read miss
    access(1'b0, 16'h0412, 16'h0, lat, mc, rdata);
    check("cold_miss_cyc", mc, 1);
    check("cold_lat", lat, 10);
    check("cold_rdata", {16'd0, rdata}, 32'h0000A1B7);
    check("cold_nrd", rd_q.size(), 8);
    bad = 0;
    for (int k = 0; k < rd_q.size(); k++) if (rd_q[k] !== 16'(16'h0410 + 2 * k)) bad++;
    check("cold_rd_addrs", bad, 0);

    // read hit after fill
    access(1'b0, 16'h0414, 16'h0, lat, mc, rdata);
    check("hit_lat", lat, 1);
    check("hit_miss_cyc", mc, 0);
    check("hit_rdata", {16'd0, rdata}, 32'h0000A1B1);
    check("hit_nrd", rd_q.size(), 0);
`ifdef DCACHE_STATS_EN
    check("stats_hit", hit_count, 32'd1);
    check("stats_miss", miss_count, 32'd1);
`endif

    // write hit, slow memory
    ack_delay = 3;
    access(1'b1, 16'h0412, 16'h1234, lat, mc, rdata);
    ack_delay = 0;
    check("wr_lat", lat, 6);
    check("wr_ncyc", wr_a.size(), 4);
    bad = 0;
    for (int k = 0; k < wr_a.size(); k++) if (wr_a[k] !== 16'h0412 || wr_d[k] !== 16'h1234) bad++;
    check("wr_hold", bad, 0);
    access(1'b0, 16'h0412, 16'h0, lat, mc, rdata);
    check("rdback_lat", lat, 1);
    check("rdback_data", {16'd0, rdata}, 32'h00001234);

    // LRU eviction
    do_reset();
    access(1'b0, 16'h0410, 16'h0, lat, mc, rdata);
    check("lru_a_miss", mc, 1);
    access(1'b0, 16'h0810, 16'h0, lat, mc, rdata);
    check("lru_b_miss", mc, 1);
    access(1'b0, 16'h0410, 16'h0, lat, mc, rdata);
    check("lru_a_hit", lat, 1);
    access(1'b0, 16'h0C10, 16'h0, lat, mc, rdata);
    check("lru_c_miss", mc, 1);
    access(1'b0, 16'h0410, 16'h0, lat, mc, rdata);
    check("lru_a2_hit_lat", lat, 1);
    check("lru_a2_data", {16'd0, rdata}, 32'h0000A1B5);
    access(1'b0, 16'h0810, 16'h0, lat, mc, rdata);
    check("lru_b2_miss", mc, 1);
    check("lru_b2_data", {16'd0, rdata}, 32'h0000ADB5);

    // reset mid-fill
    do_reset();
    @(negedge clk);
    rd_q.delete();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0412;
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    check("midfill_acks", rd_q.size(), 3);
    check("midfill_rd_before", {31'd0, bus.mem_rd}, 32'd1);
    rst = 1'b0;
    #1;
    check("midfill_rd_after", {31'd0, bus.mem_rd}, 32'd0);
    check("midfill_busy", {31'd0, bus.cpu_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    access(1'b0, 16'h0412, 16'h0, lat, mc, rdata);
    check("postrst_miss", mc, 1);
    check("postrst_lat", lat, 10);
    check("postrst_data", {16'd0, rdata}, 32'h0000A1B7);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/data_cache_nway.md
# data_cache_nway

Parametrised N-way set-associative data cache with true-LRU replacement, an internal block-fill state machine and write-through stores. It sits between the MEM stage and main memory. The block owns its tag, valid, LRU and data storage, so the external shifter and tag/data write strobes are not needed. Defaults (2-way, 64 sets, 8 × 16-bit words per block) give the current 6-bit tag / 6-bit index / 3-bit word-offset address split.

## Interface

Parameters:
- WAYS, 2: associativity; power of 2, 1..8.
- SETS, 64: sets per way; power of 2.
- WORDS, 8: 16-bit words per block; power of 2, ≥2.
- AW, 16: byte-address width.
- DW, 16: word width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  access request; sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  AW  byte address; bit 0 is ignored.
- cpu_wdata  in  DW  store data.
- cpu_rdata  out  DW  load data; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high whenever the state is not IDLE.
- miss_data_cache  out  1  one-cycle pulse in the LOOKUP cycle that misses.
- mem_rd  out  1  memory word-read request.
- mem_wr  out  1  memory word-write request.
- mem_addr  out  AW  memory byte address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; captured on the mem_ack edge.
- mem_ack  in  1  completes the current mem_rd or mem_wr; ignored when neither is asserted.

## Operation

Address fields:
- OFF_W = log2(WORDS), IDX_W = log2(SETS), TAG_W = AW−1−OFF_W−IDX_W.
- Word offset = addr[OFF_W:1]; index = addr[IDX_W+OFF_W:OFF_W+1]; tag = the remaining upper bits.

Storage is flop-based:
- Per set and way: valid, tag, WORDS data words.
- Per set and way: an age counter of log2(WAYS) bits, which is absent when WAYS=1.

States:
- IDLE → LOOKUP when cpu_req=1. Address, we and wdata are latched.
- LOOKUP: compare the latched tag against every way of the indexed set.
  - Read hit: cpu_ready=1, cpu_rdata = the hit word, update LRU, go to IDLE.
  - Write hit: write the word into the cache, update LRU, go to WRITE_MEM.
  - Miss: pulse miss_data_cache, select the victim, go to FILL.
- FILL:
  - On entry, clear the victim's valid bit and write its tag.
  - Issue mem_rd for words 0..WORDS−1 at {tag,index,k,1'b0}.
  - mem_rd stays high and mem_addr stays stable until mem_ack. The word is stored on the ack edge, and mem_addr advances in the following cycle.
  - On the ack of the last word: set valid, update LRU, drop mem_rd, go to LOOKUP (replay). The replay always hits.
- WRITE_MEM: mem_wr=1, mem_addr = latched address, mem_wdata = latched data. On mem_ack: cpu_ready=1, go to IDLE.

Policy: write-through with write-allocate. A write miss fills the block, then follows the write-hit path.

Victim selection:
- The lowest-index invalid way.
- Otherwise, the way with age = WAYS−1.

LRU update on a hit or a fill completion:
- Every way whose age is below the accessed way's old age increments.
- The accessed way's age becomes 0.
- At reset, the age of way w = w.

Boundary conditions:
- cpu_req while busy is ignored; there is no queueing.
- mem_ack in the same cycle mem_rd/mem_wr first asserts (zero-wait memory) is legal.
- mem_ack held high continuously completes one word per cycle.
- Reset mid-operation immediately deasserts all outputs and returns to IDLE. The in-flight memory transaction is abandoned.

Reset values:
- All outputs are 0.
- All valid bits are 0 and ages are as above.
- Data and tag arrays are not cleared.

## Timing

All cycle numbers are relative to T, the edge that accepts the request.
- Read hit: cpu_ready in cycle T+1.
- Write hit: mem_wr from T+2; cpu_ready in the cycle after the mem_ack cycle.
- Read miss with zero-wait memory:
  - miss_data_cache at T+1.
  - FILL words at T+2..T+1+WORDS.
  - Replay LOOKUP with cpu_ready at T+2+WORDS, which is T+10 at the default WORDS=8.
- Each memory wait cycle adds one cycle.
- cpu_ready and miss_data_cache are never high for more than one cycle.

## Configuration

- DCACHE_STATS_EN defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - Each counter increments once per accepted request, in its first LOOKUP.
  - The replay LOOKUP is not counted.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- DCACHE_STATS_EN undefined: the counter ports and logic are absent. Behaviour is otherwise identical.

## Test plan

All scenarios use default parameters. Memory returns mem_rdata = mem_addr ^ 16'hA5A5 with zero wait states unless stated.

- **Cold read miss:** reset, then read 0x0412 → miss_data_cache at T+1; mem_rd addresses 0x0410..0x041E; cpu_ready at T+10 with cpu_rdata=0xA1B7.
- **Read hit after fill:** read 0x0414 → cpu_ready at T+1, cpu_rdata=0xA1B1, no mem_rd.
- **Write hit with slow memory:** write 0x1234 to 0x0412 with mem_ack delayed 3 cycles → mem_wr held with addr 0x0412 and data 0x1234 until ack, then cpu_ready. A following read of 0x0412 returns 0x1234 at T+1.
- **LRU eviction:** read 0x0410, then 0x0810, then 0x0410, then 0x0C10 (three misses and one hit) → the block of 0x0810 is evicted. A subsequent read of 0x0410 hits; a read of 0x0810 misses.
- **Reset mid-fill:** assert rst low after 3 fill acks → mem_rd=0 immediately. After rst releases, a read of 0x0412 misses again.
- **Statistics:** with DCACHE_STATS_EN defined, run the first two scenarios → hit_count=1, miss_count=1.
